// File: rtl/ahb_manager.sv
// AHB-Lite initiator: turns single-word client read/write requests into SINGLE NONSEQ
// transfers, one outstanding at a time, and reports completion, read data and error.
module ahb_manager #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strobe,
    input  logic                    wen,
    input  logic                    ren,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    request_stall,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic                    HWRITE,
    output logic [1:0]              HTRANS,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic                    HMASTLOCK,
    output logic [DATA_WIDTH-1:0]   HWDATA,
    output logic [DATA_WIDTH/8-1:0] HWSTRB,
    input  logic [DATA_WIDTH-1:0]   HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

    state_t                    state, state_next;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   strobe_q;
    logic                      write_q;
    logic                      req;
    logic                      capture;
    logic                      completion;

    assign req           = ren | wen;
    assign capture       = (state == ST_IDLE) & req;
    assign request_stall = req & ~completion;

    assign HSIZE     = 3'($clog2(DATA_WIDTH/8));
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            write_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_q   <= addr;
                wdata_q  <= wdata;
                strobe_q <= strobe;
                write_q  <= wen;
            end
        end
    end

    always_comb begin
        state_next = state;
        HTRANS     = 2'b00;
        HADDR      = '0;
        HWRITE     = 1'b0;
        HWDATA     = '0;
        HWSTRB     = '0;
        completion = 1'b0;
        error      = 1'b0;
        rdata      = '0;
        case (state)
            ST_IDLE: begin
                if (req) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                HTRANS = 2'b10;
                HADDR  = addr_q;
                HWRITE = write_q;
                // HREADY low here is the previous owner's data phase; keep the address up
                if (HREADY) state_next = ST_DATA;
            end
            ST_DATA: begin
                HWDATA = wdata_q;
                HWSTRB = write_q ? strobe_q : '0;
                if (HREADY) begin
                    completion = 1'b1;
                    error      = HRESP;
                    state_next = ST_IDLE;
                end else if (HRESP) begin
                    state_next = ST_ERR;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    completion = 1'b1;
                    error      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (completion && !write_q) rdata = HRDATA;
    end

endmodule

// File: tb/tb_ahb_manager.sv
// Cycle-by-cycle vector table for ahb_manager plus a back-to-back read sequence that
// checks NONSEQ spacing and the constant AHB control outputs.
module tb_ahb_manager;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        request_stall;
    logic        error;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [3:0]  HWSTRB;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_manager #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .addr(addr), .wdata(wdata), .strobe(strobe), .wen(wen), .ren(ren),
        .rdata(rdata), .request_stall(request_stall), .error(error),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] a, wd;
        logic [3:0]  st;
        logic        rdy, resp;
        logic [31:0] hrd;
        logic [1:0]  e_trans;
        logic [31:0] e_haddr;
        logic        e_hwrite;
        logic [31:0] e_hwdata;
        logic [3:0]  e_hwstrb;
        logic [31:0] e_rdata;
        logic        e_stall, e_err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic rd, input logic wr, input logic [31:0] a,
        input logic [31:0] wd, input logic [3:0] st, input logic rdy, input logic resp,
        input logic [31:0] hrd, input logic [1:0] e_trans, input logic [31:0] e_haddr,
        input logic e_hwrite, input logic [31:0] e_hwdata, input logic [3:0] e_hwstrb,
        input logic [31:0] e_rdata, input logic e_stall, input logic e_err);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.st = st;
        v.rdy = rdy; v.resp = resp; v.hrd = hrd;
        v.e_trans = e_trans; v.e_haddr = e_haddr; v.e_hwrite = e_hwrite;
        v.e_hwdata = e_hwdata; v.e_hwstrb = e_hwstrb; v.e_rdata = e_rdata;
        v.e_stall = e_stall; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        int nonseq_cnt;
        int first_ns;
        int second_ns;
        HRESET = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; strobe = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

        // rst rd wr addr          wdata         st     rdy resp hrdata       | trans haddr        wr hwdata        hwstrb rdata         stall err
        vecs.push_back(mk(1,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        vecs.push_back(mk(1,1,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        // zero-wait read
        vecs.push_back(mk(0,1,0,32'h8000_0010,32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h8000_0010,32'h0,        4'h0,1,0,32'h0,        2'b10,32'h8000_0010,0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h8000_0010,32'h0,        4'h0,1,0,32'hDEAD_BEEF,2'b00,32'h0,        0,32'h0,        4'h0,32'hDEAD_BEEF,0,0));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        // write with two wait states in the data phase
        vecs.push_back(mk(0,0,1,32'h8000_0004,32'h1234_5678,4'hF,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,0,1,32'h8000_0004,32'h1234_5678,4'hF,1,0,32'h0,        2'b10,32'h8000_0004,1,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,0,1,32'h8000_0004,32'h1234_5678,4'hF,0,0,32'h0,        2'b00,32'h0,        0,32'h1234_5678,4'hF,32'h0,        1,0));
        vecs.push_back(mk(0,0,1,32'h8000_0004,32'h1234_5678,4'hF,0,0,32'h0,        2'b00,32'h0,        0,32'h1234_5678,4'hF,32'h0,        1,0));
        vecs.push_back(mk(0,0,1,32'h8000_0004,32'h1234_5678,4'hF,1,0,32'h0,        2'b00,32'h0,        0,32'h1234_5678,4'hF,32'h0,        0,0));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        // read with address-phase stall, then two-cycle error response
        vecs.push_back(mk(0,1,0,32'h7000_0000,32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h7000_0000,32'h0,        4'h0,0,0,32'h0,        2'b10,32'h7000_0000,0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h7000_0000,32'h0,        4'h0,1,0,32'h0,        2'b10,32'h7000_0000,0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h7000_0000,32'h0,        4'h0,0,1,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h7000_0000,32'h0,        4'h0,1,1,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,1));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        // reset during the data phase of a write
        vecs.push_back(mk(0,0,1,32'h0000_0010,32'hA5A5_A5A5,4'h3,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,0,1,32'h0000_0010,32'hA5A5_A5A5,4'h3,1,0,32'h0,        2'b10,32'h0000_0010,1,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(1,0,1,32'h0000_0010,32'hA5A5_A5A5,4'h3,0,0,32'h0,        2'b00,32'h0,        0,32'hA5A5_A5A5,4'h3,32'h0,        1,0));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        // ren and wen together: write wins
        vecs.push_back(mk(0,1,1,32'h0000_0020,32'h0BAD_F00D,4'hC,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,1,32'h0000_0020,32'h0BAD_F00D,4'hC,1,0,32'h0,        2'b10,32'h0000_0020,1,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,1,32'h0000_0020,32'h0BAD_F00D,4'hC,1,0,32'hFFFF_FFFF,2'b00,32'h0,        0,32'h0BAD_F00D,4'hC,32'h0,        0,0));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        // single-cycle error response in the data phase
        vecs.push_back(mk(0,1,0,32'h0000_0030,32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h0000_0030,32'h0,        4'h0,1,0,32'h0,        2'b10,32'h0000_0030,0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,1,0,32'h0000_0030,32'h0,        4'h0,1,1,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,1));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        // request dropped after capture: bus transfer still runs to completion
        vecs.push_back(mk(0,1,0,32'h0000_0040,32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        1,0));
        vecs.push_back(mk(0,0,0,32'h0000_0040,32'h0,        4'h0,1,0,32'h0,        2'b10,32'h0000_0040,0,32'h0,        4'h0,32'h0,        0,0));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));
        vecs.push_back(mk(0,0,0,32'h0,         32'h0,        4'h0,1,0,32'h0,        2'b00,32'h0,        0,32'h0,        4'h0,32'h0,        0,0));

        foreach (vecs[i]) begin
            @(negedge HCLK);
            HRESET = vecs[i].rst; ren = vecs[i].rd; wen = vecs[i].wr;
            addr = vecs[i].a; wdata = vecs[i].wd; strobe = vecs[i].st;
            HREADY = vecs[i].rdy; HRESP = vecs[i].resp; HRDATA = vecs[i].hrd;
            #1;
            check("HTRANS",        i, 32'(HTRANS),        32'(vecs[i].e_trans));
            check("HADDR",         i, HADDR,              vecs[i].e_haddr);
            check("HWRITE",        i, 32'(HWRITE),        32'(vecs[i].e_hwrite));
            check("HWDATA",        i, HWDATA,             vecs[i].e_hwdata);
            check("HWSTRB",        i, 32'(HWSTRB),        32'(vecs[i].e_hwstrb));
            check("rdata",         i, rdata,              vecs[i].e_rdata);
            check("request_stall", i, 32'(request_stall), 32'(vecs[i].e_stall));
            check("error",         i, 32'(error),         32'(vecs[i].e_err));
        end

        // Back-to-back reads with ren held: NONSEQ expected at relative cycles 1 and 4
        nonseq_cnt = 0; first_ns = -1; second_ns = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge HCLK);
            HRESET = 1'b0; ren = 1'b1; wen = 1'b0; addr = 32'h0000_0100;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0000_1000 + 32'(c);
            #1;
            check("HBURST",    100 + c, 32'(HBURST),    32'h0);
            check("HSIZE",     100 + c, 32'(HSIZE),     32'h2);
            check("HMASTLOCK", 100 + c, 32'(HMASTLOCK), 32'h0);
            if (HTRANS == 2'b10) begin
                nonseq_cnt++;
                if (first_ns < 0) first_ns = c;
                else if (second_ns < 0) second_ns = c;
            end
        end
        @(negedge HCLK);
        ren = 1'b0;
        check("b2b_nonseq_count", 200, 32'(nonseq_cnt), 32'd2);
        check("b2b_first_nonseq", 201, 32'(first_ns),   32'd1);
        check("b2b_spacing",      202, 32'(second_ns - first_ns), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
